// File: rtl/matmul_host_driver.sv
// Bus-master sequencer for the 8-bit cs/rw/comdat matrix-multiply peripheral: loads A/B operands,
// waits for the compute sweep to settle, then re-addresses and streams the result bytes out.
module matmul_host_driver #(
  parameter int unsigned LOAD_BYTES    = 128,
  parameter int unsigned READ_BYTES    = 128,
  parameter int unsigned SETTLE_CYCLES = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       mm_cs,
  output logic       mm_rw,
  output logic       mm_comdat,
  output logic [7:0] mm_wdata,
  input  logic [7:0] mm_rdata
);

  localparam logic [7:0] LoadLast   = 8'(LOAD_BYTES - 1);
  localparam logic [7:0] ReadLast   = 8'(READ_BYTES - 1);
  localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetWaddr,
    StWrite,
    StSettle,
    StSetRaddr,
    StRead,
    StDone
  } state_e;

  state_e     state_q;
  logic [7:0] byte_cnt_q;
  logic [7:0] settle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_cnt_q   <= 8'h00;
      settle_cnt_q <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StSetWaddr;
            byte_cnt_q <= 8'h00;
          end
        end
        StSetWaddr: state_q <= StWrite;
        StWrite: begin
          if (in_valid) begin
            byte_cnt_q <= byte_cnt_q + 8'd1;
            if (byte_cnt_q == LoadLast) begin
              state_q      <= StSettle;
              settle_cnt_q <= SettleInit;
            end
          end
        end
        StSettle: begin
          if (settle_cnt_q == 8'h00) begin
            state_q    <= StSetRaddr;
            byte_cnt_q <= 8'h00;
          end else begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
          end
        end
        StSetRaddr: state_q <= StRead;
        StRead: begin
          // Peripheral address only advances on transfer cycles, so backpressure is lossless.
          if (out_ready) begin
            byte_cnt_q <= byte_cnt_q + 8'd1;
            if (byte_cnt_q == ReadLast) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mm_cs     = 1'b0;
    mm_rw     = 1'b1;
    mm_comdat = 1'b0;
    mm_wdata  = 8'h00;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      StSetWaddr, StSetRaddr: begin
        mm_cs     = 1'b1;
        mm_rw     = 1'b0;
        mm_comdat = 1'b1;
      end
      StWrite: begin
        in_ready = 1'b1;
        mm_cs    = in_valid;
        mm_rw    = 1'b0;
        mm_wdata = in_data;
      end
      StRead: begin
        out_valid = 1'b1;
        out_data  = mm_rdata;
        mm_cs     = out_ready;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_matmul_host_driver.sv
// Randomized bench for matmul_host_driver: a behavioural peripheral, a transaction-level timeline
// model and golden 8x8 product image; a second instance checks the minimum settle gap.
module tb_matmul_host_driver;

  localparam int L   = 128;
  localparam int R   = 128;
  localparam int S   = 40;
  localparam int S2  = 33;
  localparam int Big = 32'h3fff_ffff;

  typedef logic [7:0] img_t[128];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, in_ready, out_valid, mm_cs, mm_rw, mm_comdat;
  logic [7:0] out_data, mm_wdata, mm_rdata;
  logic       busy2, done2, in_ready2, out_valid2, mm_cs2, mm_rw2, mm_comdat2;
  logic [7:0] out_data2, mm_wdata2, mm_rdata2;

  always #5 clk = ~clk;

  matmul_host_driver dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mm_cs(mm_cs), .mm_rw(mm_rw), .mm_comdat(mm_comdat), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata)
  );

  matmul_host_driver #(.SETTLE_CYCLES(S2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .mm_cs(mm_cs2), .mm_rw(mm_rw2), .mm_comdat(mm_comdat2), .mm_wdata(mm_wdata2),
    .mm_rdata(mm_rdata2)
  );

  // Result byte idx of C = A*B: entry idx/2 as 16-bit little-endian; A at 0..63, B at 64..127.
  function automatic logic [7:0] calc_byte(input img_t m, input int idx);
    int e, i, j;
    logic [15:0] acc;
    e = idx / 2;
    i = e / 8;
    j = e % 8;
    acc = 16'h0000;
    for (int k = 0; k < 8; k++) acc += 16'(m[i*8+k]) * 16'(m[64+k*8+j]);
    return (idx % 2 == 0) ? acc[7:0] : acc[15:8];
  endfunction

  // Behavioural peripheral: command loads the address, data cycles write/read and advance it.
  img_t       pmem;
  logic [7:0] paddr = 8'h00;
  logic [7:0] paddr2 = 8'h00;
  always @(posedge clk) begin
    if (mm_cs) begin
      if (mm_comdat) paddr <= mm_wdata;
      else begin
        if (!mm_rw) pmem[paddr[6:0]] <= mm_wdata;
        paddr <= paddr + 8'd1;
      end
    end
    if (mm_cs2) begin
      if (mm_comdat2) paddr2 <= mm_wdata2;
      else paddr2 <= paddr2 + 8'd1;
    end
  end
  assign mm_rdata  = calc_byte(pmem, int'(paddr[6:0]));
  assign mm_rdata2 = calc_byte(pmem, int'(paddr2[6:0]));

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  img_t src, gold, rx, rx1;

  // Transaction model state
  bit m_active = 1'b0;
  int cmd1 = 0, cmd2 = Big, wr_cnt = 0, rd_cnt = 0, stalls = 0, rd_end = Big, k_smp = 0;
  int tx_done_cnt = 0, last_lat = 0;
  bit w2_done = 1'b0;
  int w2_cnt = 0, last_w2 = 0, gap2 = 0, r2_cnt = 0, tx2_cnt = 0;

  always @(negedge clk) begin : compare
    bit e_busy, e_cmd, e_ir, e_ov, e_done;
    logic [7:0] e_wd, e_od;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_mm_cs", mm_cs, 0);
      chk("rst_mm_rw", mm_rw, 1);
      chk("rst_mm_comdat", mm_comdat, 0);
      chk("rst_mm_wdata", mm_wdata, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_mm_rw2", mm_rw2, 1);
      m_active = 1'b0;
      w2_done = 1'b0;
      w2_cnt = 0;
      gap2 = 0;
      r2_cnt = 0;
    end else begin
      e_busy = m_active && cyc >= cmd1;
      e_cmd  = e_busy && (cyc == cmd1 || cyc == cmd2);
      e_ir   = e_busy && cyc > cmd1 && wr_cnt < L;
      e_ov   = e_busy && cyc > cmd2 && rd_cnt < R;
      e_done = e_busy && rd_cnt == R && cyc == rd_end + 1;
      e_wd   = (e_ir && !e_cmd) ? in_data : 8'h00;
      e_od   = e_ov ? gold[rd_cnt] : 8'h00;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("mm_cs", mm_cs, e_cmd | (e_ir & in_valid) | (e_ov & out_ready));
      chk("mm_rw", mm_rw, !(e_cmd | e_ir));
      chk("mm_comdat", mm_comdat, e_cmd);
      chk("mm_wdata", mm_wdata, e_wd);
      chk("out_data", out_data, e_od);

      if (e_ir && in_valid) begin
        wr_cnt++;
        if (wr_cnt == L) cmd2 = cyc + S + 1;
      end
      if (e_ov && out_ready) begin
        rx[rd_cnt] = out_data;
        rd_cnt++;
        if (rd_cnt == R) rd_end = cyc;
      end
      if ((e_ir && !in_valid) || (e_ov && !out_ready)) stalls++;
      if (e_done) begin
        last_lat = cyc - k_smp;
        chk("latency", last_lat, 3 + S + L + R + stalls);
        m_active = 1'b0;
        tx_done_cnt++;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        k_smp = cyc;
        cmd1 = cyc + 1;
        cmd2 = Big;
        rd_end = Big;
        wr_cnt = 0;
        rd_cnt = 0;
        stalls = 0;
      end

      // Short-settle instance: gap length and read stream.
      if (w2_done && !mm_cs2) gap2++;
      if (in_ready2 && in_valid) begin
        chk("mm_wdata2", mm_wdata2, in_data);
        w2_cnt++;
        if (w2_cnt == L) begin
          last_w2 = cyc;
          w2_done = 1'b1;
          gap2 = 0;
        end
      end
      if (mm_cs2 && mm_comdat2 && w2_done) begin
        chk("settle_gap_idle", gap2, S2);
        chk("settle_gap_cmd", cyc - last_w2 - 1, S2);
        w2_done = 1'b0;
      end
      if (out_valid2 && out_ready) begin
        if (r2_cnt < R) chk("out_data2", out_data2, gold[r2_cnt]);
        else chk("rd_overrun2", r2_cnt, R - 1);
        r2_cnt++;
      end
      if (done2) begin
        chk("rd_count2", r2_cnt, R);
        r2_cnt = 0;
        w2_cnt = 0;
        tx2_cnt++;
      end
    end
  end

  // Valid/ready source and sink
  int src_idx = 0;
  bit bp_mode = 1'b0;
  bit tog = 1'b0;
  bit in_fire;
  always begin
    @(negedge clk);
    in_fire = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (in_fire) src_idx++;
    tog = !tog;
    in_valid = bp_mode ? tog : 1'b1;
    in_data = (src_idx < L) ? src[src_idx] : 8'h00;
    out_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input bit rnd);
    for (int i = 0; i < 64; i++) begin
      src[i]    = rnd ? 8'($urandom) : ((i / 8 == i % 8) ? 8'h01 : 8'h00);
      src[64+i] = rnd ? 8'($urandom) : 8'(i);
    end
    for (int i = 0; i < 128; i++) gold[i] = calc_byte(src, i);
    src_idx = 0;
    in_data = src[0];
  endtask

  task automatic run(input bit bp, input bit poke);
    int n0, n2, t;
    n0 = tx_done_cnt;
    n2 = tx2_cnt;
    bp_mode = bp;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while ((tx_done_cnt == n0 || tx2_cnt == n2) && t < 3000) begin
      tick();
      t++;
      start = poke && (t == 60 || t == 220);
    end
    start = 1'b0;
    if (t >= 3000) chk("timeout", t, 0);
    tick();
    tick();
  endtask

  initial begin
    int nbad, t;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Streaming, A = identity, B = 0x00..0x3F
    load(1'b0);
    chk("pin_gold_126", gold[126], 8'h3f);
    run(1'b0, 1'b0);
    chk("done_at_k299", last_lat, 299);
    chk("pin_rx0", rx[0], 8'h00);
    chk("pin_rx2", rx[2], 8'h01);
    chk("pin_rx20", rx[20], 8'h0a);
    chk("pin_rx21", rx[21], 8'h00);
    chk("pin_rx126", rx[126], 8'h3f);
    rx1 = rx;

    // Same data under backpressure
    load(1'b0);
    run(1'b1, 1'b0);
    nbad = 0;
    for (int i = 0; i < 128; i++) if (rx[i] !== rx1[i]) nbad++;
    chk("bp_vs_stream", nbad, 0);

    // Start pulses while busy must not disturb the timeline
    load(1'b1);
    run(1'b0, 1'b1);
    chk("poke_k299", last_lat, 299);

    // Reset mid-WRITE, then a fresh full transaction
    load(1'b1);
    bp_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (wr_cnt < 50 && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) chk("timeout_wr50", t, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    src_idx = 0;
    in_data = src[0];
    tick();
    run(1'b0, 1'b0);
    chk("after_rst_k299", last_lat, 299);

    // Random data with backpressure
    load(1'b1);
    run(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/matmul_host_driver.md
# matmul_host_driver

Bus-master sequencer for the 8-bit `cs`/`rw`/`comdat` matrix-multiply peripheral, sitting between a byte stream source/sink and the peripheral's bus. On `start` it:
- sets the peripheral address to 0 with a command cycle;
- streams A then B operand bytes from a valid/ready source;
- waits for the peripheral's free-running compute sweep to settle;
- re-addresses to 0 and streams the result bytes to a valid/ready sink.

It replaces hand-sequenced CPU bus writes for bulk operand loads and result reads.

## Interface
Parameters:
- `LOAD_BYTES`, default 128: operand bytes written (A at 0–63, then B at 64–127). Range 1–128.
- `READ_BYTES`, default 128: result bytes read from address 0 upward. Range 1–128.
- `SETTLE_CYCLES`, default 40: idle cycles between the last write and the read command. Range 33–255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: begin a transaction; sampled only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `in_data` in 8: operand byte.
- `in_valid` in 1: operand byte valid.
- `in_ready` out 1: operand byte accepted.
- `out_data` out 8: result byte.
- `out_valid` out 1: result byte valid.
- `out_ready` in 1: sink accepts the result byte.
- `mm_cs` out 1: peripheral chip select.
- `mm_rw` out 1: 1 = read, 0 = write.
- `mm_comdat` out 1: 1 = command (address load), 0 = data.
- `mm_wdata` out 8: to peripheral `data_in`.
- `mm_rdata` in 8: from peripheral `data_out`; combinational, equals the result byte at the current address.

## Operation
- States: IDLE, SET_WADDR, WRITE, SETTLE, SET_RADDR, READ, DONE. Only the state register, an 8-bit byte counter and an 8-bit settle counter are registered. All bus and handshake outputs decode combinationally from state and handshake inputs.
- Default output values, applied in any state not listed below: `mm_cs`=0, `mm_rw`=1, `mm_comdat`=0, `mm_wdata`=0x00, `in_ready`=0, `out_valid`=0, `out_data`=0x00.
- **IDLE**
  - `start`=1 → SET_WADDR; byte counter cleared.
  - `start` while not in IDLE is ignored.
- **SET_WADDR** (one cycle)
  - Drives `mm_cs`=1, `mm_rw`=0, `mm_comdat`=1, `mm_wdata`=0x00.
  - → WRITE.
- **WRITE**
  - `in_ready`=1. Drives `mm_cs`=`in_valid`, `mm_rw`=0, `mm_comdat`=0, `mm_wdata`=`in_data`.
  - Each transfer (`in_valid`&`in_ready`) increments the byte counter.
  - On the transfer that makes the count equal `LOAD_BYTES` → SETTLE; settle counter loaded with `SETTLE_CYCLES`-1.
- **SETTLE**
  - All bus outputs at default values.
  - Settle counter decrements each cycle; at 0 → SET_RADDR; byte counter cleared.
- **SET_RADDR** (one cycle)
  - Same drive as SET_WADDR.
  - → READ.
- **READ**
  - `out_valid`=1, `out_data`=`mm_rdata`. Drives `mm_cs`=`out_ready`, `mm_rw`=1, `mm_comdat`=0.
  - The peripheral advances its address only on transfer cycles, so no byte is skipped or repeated under backpressure.
  - On the transfer that makes the count equal `READ_BYTES` → DONE.
- **DONE** (one cycle)
  - `done`=1.
  - → IDLE.
- Reset, asserted at any time (including mid-transfer):
  - State → IDLE, counters → 0, all outputs at default values immediately.
  - The peripheral address is left stale; the next transaction re-addresses it, so no cleanup cycle is required.
- Byte counter width: 8 bits, no wrap within the legal parameter range.

## Timing
- Reset values of outputs: `busy`=0, `done`=0, `in_ready`=0, `out_valid`=0, `out_data`=0x00, `mm_cs`=0, `mm_rw`=1, `mm_comdat`=0, `mm_wdata`=0x00.
- With `start` sampled at edge k, `in_valid` and `out_ready` held high, and default parameters:
  - SET_WADDR: cycle k+1.
  - WRITE: cycles k+2 to k+129.
  - SETTLE: cycles k+130 to k+169.
  - SET_RADDR: cycle k+170.
  - READ: cycles k+171 to k+298.
  - DONE: cycle k+299, with `done`=1.
  - `busy`=1 from k+1 through k+299.
- General latency: 3 + `SETTLE_CYCLES` + `LOAD_BYTES` + `READ_BYTES` cycles, plus the number of stall cycles.
- Minimum settle of 33 cycles covers two full 16-step compute sweeps plus the one-cycle result-write lag.
- Combinational paths exist from `in_valid`/`in_data` to `mm_cs`/`mm_wdata` and from `out_ready` to `mm_cs`. The integrator must budget for these.

## Test plan
- **Reset:** hold `rst`=1 mid-run → within the same cycle all outputs take reset values. Release and run a full transaction → result matches golden.
- **Full run at default parameters** with streaming handshakes. A = identity, B = bytes 0x00–0x3F.
  - Exactly one command 0x00 at k+1 and one at k+170.
  - 128 write strobes in order.
  - `done` at k+299.
  - 128 read bytes match the golden 8×8 product image.
- **Backpressure:** `in_valid` toggled every other cycle, `out_ready` random at 50%.
  - `mm_cs` asserted only on transfer cycles.
  - Peripheral address sequence is 0–127 with no gaps or repeats.
  - Result identical to the streaming run.
- **Start while busy:** pulse `start` during WRITE and during READ → no extra command cycle; timeline unchanged.
- **Reset mid-WRITE:** assert `rst` after 50 bytes, then `start` again → fresh SET_WADDR with 0x00, 128 full writes, correct result.
- **Settle gap:** with `SETTLE_CYCLES`=33 → exactly 33 cycles with `mm_cs`=0 between the last write strobe and the SET_RADDR command; result is correct.
